// File: rtl/reg_file_responder_if.sv
// Register-port bundle between the cycle sequencer (master) and the register-file responder (slave).
// Carries the write/read strobes, branch controls and the registered responses.
interface reg_file_responder_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       regaddrIn;
    logic [DATA_W-1:0] regdataIn;
    logic              regwr;
    logic [31:0]       regaddrOut1;
    logic [31:0]       regaddrOut2;
    logic              regrd1;
    logic              regrd2;
    logic              pc_inc;
    logic              bf;
    logic [DATA_W-1:0] branchimm;
    logic [DATA_W-1:0] regdata1;
    logic [DATA_W-1:0] regdata2;
    logic              rd_valid1;
    logic              rd_valid2;
    logic [DATA_W-1:0] pc;
    logic              addr_err;

    modport master (
        output regaddrIn, regdataIn, regwr, regaddrOut1, regaddrOut2, regrd1, regrd2,
               pc_inc, bf, branchimm,
        input  regdata1, regdata2, rd_valid1, rd_valid2, pc, addr_err
    );

    modport slave (
        input  regaddrIn, regdataIn, regwr, regaddrOut1, regaddrOut2, regrd1, regrd2,
               pc_inc, bf, branchimm,
        output regdata1, regdata2, rd_valid1, rd_valid2, pc, addr_err
    );
endinterface

// File: rtl/reg_file_responder.sv
// Register file with PC (top index): one write and two read ports, 1-cycle registered reads.
// No backpressure: every strobe is accepted on its edge; all outputs come straight from flops.
module reg_file_responder #(
    parameter int                NUM_REGS = 16,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    reg_file_responder_if.slave  bus
);
    localparam int          IDX_W  = $clog2(NUM_REGS);
    localparam logic [31:0] PC_IDX = 32'(NUM_REGS - 1);
    localparam logic [31:0] LIMIT  = 32'(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS-1];
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] regdata1_q, regdata1_d;
    logic [DATA_W-1:0] regdata2_q, regdata2_d;
    logic              rd_valid1_q, rd_valid2_q;
    logic              addr_err_q, addr_err_d;

    logic [31:0]       waddr, raddr1, raddr2;
    logic [DATA_W-1:0] wdata;
    logic              wr_gpr, wr_pc, wr_bad, rd1_bad, rd2_bad;

    assign waddr  = bus.regaddrIn;
    assign wdata  = bus.regdataIn;
    assign raddr1 = bus.regaddrOut1;
    assign raddr2 = bus.regaddrOut2;

    assign wr_gpr  = bus.regwr && (waddr < PC_IDX);
    assign wr_pc   = bus.regwr && (waddr == PC_IDX);
    assign wr_bad  = bus.regwr && (waddr >= LIMIT);
    assign rd1_bad = bus.regrd1 && (raddr1 >= LIMIT);
    assign rd2_bad = bus.regrd2 && (raddr2 >= LIMIT);

    // PC reads see the pre-update value; GPR reads forward a same-edge write.
    function automatic logic [DATA_W-1:0] read_word(input logic [31:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (addr == PC_IDX) begin
            val = pc_q + DATA_W'(8);
        end else if (addr < PC_IDX) begin
            if (wr_gpr && (waddr == addr)) val = wdata;
            else                           val = regs_q[addr[IDX_W-1:0]];
        end
        return val;
    endfunction

    always_comb begin
        regdata1_d = bus.regrd1 ? read_word(raddr1) : regdata1_q;
        regdata2_d = bus.regrd2 ? read_word(raddr2) : regdata2_q;
        addr_err_d = wr_bad | rd1_bad | rd2_bad;
        if (wr_pc)            pc_d = wdata & ~DATA_W'(3);
        else if (bus.bf)      pc_d = pc_q + DATA_W'(8) + bus.branchimm;
        else if (bus.pc_inc)  pc_d = pc_q + DATA_W'(4);
        else                  pc_d = pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= '0;
            pc_q        <= PC_RESET;
            regdata1_q  <= '0;
            regdata2_q  <= '0;
            rd_valid1_q <= 1'b0;
            rd_valid2_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            if (wr_gpr) regs_q[waddr[IDX_W-1:0]] <= wdata;
            pc_q        <= pc_d;
            regdata1_q  <= regdata1_d;
            regdata2_q  <= regdata2_d;
            rd_valid1_q <= bus.regrd1;
            rd_valid2_q <= bus.regrd2;
            addr_err_q  <= addr_err_d;
        end
    end

    assign bus.regdata1  = regdata1_q;
    assign bus.regdata2  = regdata2_q;
    assign bus.rd_valid1 = rd_valid1_q;
    assign bus.rd_valid2 = rd_valid2_q;
    assign bus.pc        = pc_q;
    assign bus.addr_err  = addr_err_q;
endmodule

// File: tb/tb_reg_file_responder.sv
// Directed bench for reg_file_responder: reset, write/read, forwarding, PC priority and wrap, bad indices.
module tb_reg_file_responder;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    reg_file_responder_if #(.DATA_W(32)) bus ();

    reg_file_responder #(
        .NUM_REGS(16),
        .DATA_W  (32),
        .PC_RESET(32'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.regwr  = 1'b0;
        bus.regrd1 = 1'b0;
        bus.regrd2 = 1'b0;
        bus.pc_inc = 1'b0;
        bus.bf     = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bus.regaddrIn   = '0;
        bus.regdataIn   = '0;
        bus.regaddrOut1 = '0;
        bus.regaddrOut2 = '0;
        bus.branchimm   = '0;
        idle();
        tick();
        tick();
        check("rst_regdata1", bus.regdata1, 32'h0);
        check("rst_regdata2", bus.regdata2, 32'h0);
        check("rst_valid1", {31'b0, bus.rd_valid1}, 32'h0);
        check("rst_valid2", {31'b0, bus.rd_valid2}, 32'h0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_err", {31'b0, bus.addr_err}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Write R3, read it back next cycle
        bus.regwr = 1'b1; bus.regaddrIn = 32'd3; bus.regdataIn = 32'hDEADBEEF;
        tick();
        check("wr_no_valid", {31'b0, bus.rd_valid1}, 32'h0);
        idle();
        bus.regrd1 = 1'b1; bus.regaddrOut1 = 32'd3;
        tick();
        check("rd_r3_data", bus.regdata1, 32'hDEADBEEF);
        check("rd_r3_valid", {31'b0, bus.rd_valid1}, 32'h1);
        idle();
        tick();
        check("rd_valid_drop", {31'b0, bus.rd_valid1}, 32'h0);
        check("rd_hold", bus.regdata1, 32'hDEADBEEF);

        // Same-edge write/read forwarding
        bus.regwr = 1'b1; bus.regaddrIn = 32'd5; bus.regdataIn = 32'h1234;
        bus.regrd2 = 1'b1; bus.regaddrOut2 = 32'd5;
        tick();
        check("fwd_data", bus.regdata2, 32'h1234);
        check("fwd_valid2", {31'b0, bus.rd_valid2}, 32'h1);
        check("fwd_valid1_idle", {31'b0, bus.rd_valid1}, 32'h0);
        idle();
        bus.regrd1 = 1'b1; bus.regaddrOut1 = 32'd5;
        bus.regrd2 = 1'b1; bus.regaddrOut2 = 32'd5;
        tick();
        check("dual_rd1", bus.regdata1, 32'h1234);
        check("dual_rd2", bus.regdata2, 32'h1234);

        // PC: explicit load, branch beats pc_inc, R15 read is pc+8
        idle();
        bus.regwr = 1'b1; bus.regaddrIn = 32'd15; bus.regdataIn = 32'h100;
        tick();
        check("pc_load", bus.pc, 32'h100);
        idle();
        bus.bf = 1'b1; bus.branchimm = 32'hFFFFFFF8; bus.pc_inc = 1'b1;
        tick();
        check("branch_wins", bus.pc, 32'h100);
        idle();
        bus.regrd1 = 1'b1; bus.regaddrOut1 = 32'd15;
        tick();
        check("rd_r15", bus.regdata1, 32'h108);
        idle();
        bus.regwr = 1'b1; bus.regaddrIn = 32'd15; bus.regdataIn = 32'h400;
        bus.regrd2 = 1'b1; bus.regaddrOut2 = 32'd15; bus.bf = 1'b1;
        tick();
        check("rd_r15_old", bus.regdata2, 32'h108);
        check("wr_beats_bf", bus.pc, 32'h400);

        // PC wrap on increment, alignment on write
        idle();
        bus.regwr = 1'b1; bus.regaddrIn = 32'd15; bus.regdataIn = 32'hFFFFFFFC;
        tick();
        idle();
        bus.pc_inc = 1'b1;
        tick();
        check("pc_inc_wrap", bus.pc, 32'h0);
        idle();
        bus.regwr = 1'b1; bus.regaddrIn = 32'd15; bus.regdataIn = 32'h203;
        tick();
        check("pc_align", bus.pc, 32'h200);
        idle();
        bus.pc_inc = 1'b1;
        tick();
        check("pc_inc", bus.pc, 32'h204);
        idle();
        bus.regwr = 1'b1; bus.regaddrIn = 32'd15; bus.regdataIn = 32'hFFFFFFF0;
        tick();
        idle();
        bus.bf = 1'b1; bus.branchimm = 32'h10;
        tick();
        check("bf_wrap", bus.pc, 32'h8);
        check("pc_hold_err", {31'b0, bus.addr_err}, 32'h0);

        // Out-of-range indices
        idle();
        bus.regwr = 1'b1; bus.regaddrIn = 32'd16; bus.regdataIn = 32'hAAAA5555;
        bus.regrd1 = 1'b1; bus.regaddrOut1 = 32'd20;
        tick();
        check("bad_rd_data", bus.regdata1, 32'h0);
        check("bad_rd_valid", {31'b0, bus.rd_valid1}, 32'h1);
        check("bad_err", {31'b0, bus.addr_err}, 32'h1);
        idle();
        bus.regrd1 = 1'b1; bus.regaddrOut1 = 32'd0;
        bus.regrd2 = 1'b1; bus.regaddrOut2 = 32'd3;
        tick();
        check("err_pulse", {31'b0, bus.addr_err}, 32'h0);
        check("r0_untouched", bus.regdata1, 32'h0);
        check("r3_untouched", bus.regdata2, 32'hDEADBEEF);
        check("pc_untouched", bus.pc, 32'h8);

        // Reset mid-access: read and write in flight are dropped
        idle();
        bus.regwr = 1'b1; bus.regaddrIn = 32'd3; bus.regdataIn = 32'h55;
        bus.regrd1 = 1'b1; bus.regaddrOut1 = 32'd3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid1", {31'b0, bus.rd_valid1}, 32'h0);
        check("mid_rst_data2", bus.regdata2, 32'h0);
        check("mid_rst_pc", bus.pc, 32'h0);
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        bus.regrd1 = 1'b1; bus.regaddrOut1 = 32'd3;
        bus.regrd2 = 1'b1; bus.regaddrOut2 = 32'd5;
        tick();
        check("post_rst_r3", bus.regdata1, 32'h0);
        check("post_rst_r5", bus.regdata2, 32'h0);
        check("post_rst_valid", {31'b0, bus.rd_valid1}, 32'h1);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
